// File: rtl/decoder_3to8.sv
// 3-to-8 one-hot decoder with enable, selectable output polarity and registered/combinational timing.
// Optional build macro DECODER_3TO8_HOLD_EN: in registered mode, G=0 holds OUT instead of clearing it.
module decoder_3to8 #(
  parameter bit OUT_ACTIVE_LOW = 1'b0,
  parameter bit REGISTERED     = 1'b1
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       G,
  input  logic [2:0] SEL,
  output logic [7:0] OUT,
  output logic       VALID
);

  // XOR mask applied last, so reset/idle values invert along with the decode.
  localparam logic [7:0] POL_MASK = OUT_ACTIVE_LOW ? 8'hFF : 8'h00;

  logic [7:0] next_out;

  // NOTE: the default assignment before the if keeps this purely combinational (no latch).
  // SEL is only used as an index when G=1, so X/Z on SEL cannot reach OUT while disabled.
  always_comb begin
    next_out = 8'h00;
    if (G) next_out[SEL] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments; reset is asynchronous.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) VALID <= 1'b0;
    else        VALID <= G;
  end

  generate
    if (REGISTERED) begin : g_registered
      logic [7:0] out_q;

      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          out_q <= 8'h00;
        end else begin
`ifdef DECODER_3TO8_HOLD_EN
          if (G) out_q <= next_out;
`else
          out_q <= next_out;
`endif
        end
      end

      assign OUT = out_q ^ POL_MASK;
    end else begin : g_combinational
      assign OUT = next_out ^ POL_MASK;
    end
  endgenerate

endmodule

// File: tb/tb_decoder_3to8.sv
// Self-checking bench for decoder_3to8: table sweep, directed corners and randomized model comparison
// across the default, active-low and combinational configurations.
module tb_decoder_3to8;

  logic       CLK;
  logic       RST_N;
  logic       G;
  logic [2:0] SEL;
  logic [7:0] out_reg, out_al, out_comb;
  logic       valid_reg, valid_al, valid_comb;

  int errors = 0;
  int checks = 0;

`ifdef DECODER_3TO8_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  decoder_3to8 dut (
    .CLK(CLK), .RST_N(RST_N), .G(G), .SEL(SEL), .OUT(out_reg), .VALID(valid_reg)
  );

  decoder_3to8 #(.OUT_ACTIVE_LOW(1'b1)) dut_al (
    .CLK(CLK), .RST_N(RST_N), .G(G), .SEL(SEL), .OUT(out_al), .VALID(valid_al)
  );

  decoder_3to8 #(.REGISTERED(1'b0)) dut_comb (
    .CLK(CLK), .RST_N(RST_N), .G(G), .SEL(SEL), .OUT(out_comb), .VALID(valid_comb)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference state: active-high view of the registered output and the expected VALID.
  logic [7:0] exp_hi;
  logic       exp_valid;

  typedef struct {
    logic       g;
    logic [2:0] sel;
    logic [7:0] exp_out;
    logic       exp_valid;
  } vec_t;

  vec_t vecs[16];

  function automatic logic [7:0] decode_ref(input logic g, input int sel);
    int v;
    v = g ? (2 ** sel) : 0;
    return v[7:0];
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_edge(input logic g, input int sel);
    exp_valid = g;
    if (g) exp_hi = decode_ref(g, sel);
    else if (!HOLD) exp_hi = 8'h00;
  endtask

  task automatic model_reset();
    exp_hi    = 8'h00;
    exp_valid = 1'b0;
  endtask

  // Drive inputs between edges, check the combinational instance, clock, then check registered outputs.
  task automatic do_cycle(input logic g, input logic [2:0] sel, input string tag);
    G   = g;
    SEL = sel;
    #1;
    check({tag, "_comb_out"}, out_comb, decode_ref(g, int'(sel)));
    @(posedge CLK);
    model_edge(g, int'(sel));
    #1;
    check({tag, "_out"},        out_reg,    exp_hi);
    check({tag, "_valid"},      valid_reg,  exp_valid);
    check({tag, "_al_out"},     out_al,     ~exp_hi);
    check({tag, "_comb_valid"}, valid_comb, exp_valid);
  endtask

  // Assert reset mid-cycle, check immediate effect, release, check hold until the next edge.
  task automatic mid_reset(input string tag);
    #2;
    RST_N = 1'b0;
    #1;
    model_reset();
    check({tag, "_rst_out"},       out_reg,    8'h00);
    check({tag, "_rst_valid"},     valid_reg,  1'b0);
    check({tag, "_rst_al_out"},    out_al,     8'hFF);
    check({tag, "_rst_comb_out"},  out_comb,   decode_ref(G, int'(SEL)));
    check({tag, "_rst_comb_vld"},  valid_comb, 1'b0);
    #2;
    RST_N = 1'b1;
    #1;
    check({tag, "_rel_out"},   out_reg,   8'h00);
    check({tag, "_rel_valid"}, valid_reg, 1'b0);
    check({tag, "_rel_al"},    out_al,    8'hFF);
  endtask

  initial begin
    logic [7:0] onehot [8];
    onehot = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    for (int i = 0; i < 16; i++) begin
      vecs[i].g         = (i >= 8);
      vecs[i].sel       = 3'(i % 8);
      vecs[i].exp_out   = (i >= 8) ? onehot[i % 8] : 8'h00;
      vecs[i].exp_valid = (i >= 8);
    end

    // Power-on reset.
    RST_N = 1'b0;
    G     = 1'b0;
    SEL   = 3'd0;
    model_reset();
    #2;
    check("por_out",   out_reg,   8'h00);
    check("por_valid", valid_reg, 1'b0);
    check("por_al",    out_al,    8'hFF);
    #6;
    RST_N = 1'b1;
    #1;
    check("por_rel_out",   out_reg,   8'h00);
    check("por_rel_valid", valid_reg, 1'b0);

    // Exhaustive sweep against the hand-written table.
    for (int i = 0; i < 16; i++) begin
      do_cycle(vecs[i].g, vecs[i].sel, $sformatf("sweep%0d", i));
      check($sformatf("tbl%0d_out", i),   out_reg,   vecs[i].exp_out);
      check($sformatf("tbl%0d_valid", i), valid_reg, vecs[i].exp_valid);
      check($sformatf("tbl%0d_al", i),    out_al,    ~vecs[i].exp_out);
    end

    // Latency: new inputs just after an edge are not visible until the following edge.
    G   = 1'b1;
    SEL = 3'd5;
    #2;
    check("lat_before", out_reg, 8'h80);
    @(posedge CLK);
    model_edge(1'b1, 5);
    #1;
    check("lat_after", out_reg, 8'h20);

    // Polarity corners.
    do_cycle(1'b1, 3'd2, "pol_sel2");
    check("pol_fb", out_al, 8'hFB);
    do_cycle(1'b0, 3'd2, "pol_idle");
    check("pol_ff", out_al, 8'hFF);

    // Hold feature sequence: G=1 SEL=6, then G=0 SEL=1.
    do_cycle(1'b1, 3'd6, "hold_a");
    check("hold_a_40", out_reg, 8'h40);
    check("hold_a_v1", valid_reg, 1'b1);
    do_cycle(1'b0, 3'd1, "hold_b");
    check("hold_b_out", out_reg, HOLD ? 8'h40 : 8'h00);
    check("hold_b_v0",  valid_reg, 1'b0);

    // X on SEL while disabled must not disturb OUT.
    G   = 1'b0;
    SEL = 3'bxxx;
    #1;
    check("xsel_comb", out_comb, 8'h00);
    @(posedge CLK);
    model_edge(1'b0, 0);
    #1;
    check("xsel_reg", out_reg, HOLD ? 8'h40 : 8'h00);

    // Combinational mode: zero latency, no edge needed.
    G   = 1'b1;
    SEL = 3'd7;
    #1;
    check("comb_sel7", out_comb, 8'h80);

    // Mid-operation reset, after the registered output holds a live decode.
    do_cycle(1'b1, 3'd3, "pre_rst");
    mid_reset("mid");
    do_cycle(1'b0, 3'd4, "post_rst_idle");
    check("post_rst_idle_out", out_reg, 8'h00);

    // Randomized back-to-back traffic against the reference model, with occasional resets.
    for (int n = 0; n < 300; n++) begin
      do_cycle(1'($urandom), 3'($urandom), $sformatf("rnd%0d", n));
      if ($urandom_range(0, 39) == 0) mid_reset($sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
